// File: rtl/mem_port_arbiter_pkg.sv
// arb_pkg: shared constants and FSM state type for mem_port_arbiter.
// NREQ requesters, SEL_W-bit mux select, CNT_W-bit timeout counter.
package arb_pkg;
   localparam int NREQ = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 8;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake bundle between the arbiter, its requesters and the memory.
// req/mem_ready flow into the arbiter; grant/sel/busy/mem_valid/done/err flow out.
// master = arbiter side, slave = requester/memory side.
interface mem_port_arbiter_if import arb_pkg::*; ();
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] done;
   logic [SEL_W-1:0] sel;
   logic busy;
   logic mem_valid;
   logic mem_ready;
   logic err;
   modport master (input req, mem_ready, output grant, sel, busy, mem_valid, done, err);
   modport slave (output req, mem_ready, input grant, sel, busy, mem_valid, done, err);
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr.
// Ports: req (request vector), ptr (search start), win (winning index), any (some request set).
module rr_pick import arb_pkg::*; (
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] win,
   output logic             any
);
   logic [NREQ-1:0] rot;
   logic [SEL_W-1:0] off;
   // rot[j] = req[(ptr+j) mod 4], so the first set bit of rot is the search offset
   assign rot = NREQ'({req, req} >> ptr);
   assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   assign win = ptr + off;
   assign any = |req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter/sequencer for the single shared memory port.
// Ports: clk, rst (sync active-high), bus (mem_port_arbiter_if.master:
//   req in, mem_ready in, grant/sel/busy/mem_valid/done/err out).
// Optional feature macro ARB_TIMEOUT_EN: aborts a BUSY interval after TIMEOUT cycles with err.
module mem_port_arbiter import arb_pkg::*; #(
   parameter int N = 32,
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.master bus
);
   state_t state, state_n;
   logic [SEL_W-1:0] ptr, sel_q, win;
   logic [NREQ-1:0] grant_q;
   logic any, abort, finish;
   if (N < 1 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
      $error("mem_port_arbiter: illegal N or TIMEOUT");
   end
   rr_pick u_pick (.req(bus.req), .ptr(ptr), .win(win), .any(any));
`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   // held at zero in IDLE so it starts from zero on every BUSY entry
   always_ff @(posedge clk)
      if (rst || state == IDLE) cnt <= '0;
      else if (!bus.mem_ready) cnt <= cnt + 1'b1;
   assign abort = state == BUSY && !bus.mem_ready && cnt == CNT_W'(TIMEOUT - 1);
`else
   assign abort = 1'b0;
`endif
   assign finish = state == BUSY && (bus.mem_ready || abort);
   always_comb state_n = state == IDLE ? (any ? BUSY : IDLE) : (finish ? IDLE : BUSY);
   // sel_q is only loaded on a new grant so the data muxes stay quiet while idle
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         grant_q <= '0;
         sel_q <= '0;
         ptr <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && any) begin
            grant_q <= NREQ'(1) << win;
            sel_q <= win;
         end
         if (finish) begin
            grant_q <= '0;
            ptr <= sel_q + 1'b1;
         end
      end
   assign bus.grant = grant_q;
   assign bus.sel = sel_q;
   assign bus.busy = state == BUSY;
   assign bus.mem_valid = state == BUSY;
   assign bus.done = finish ? grant_q : '0;
   assign bus.err = abort;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a cycle-level reference model of the arbiter.
module tb_mem_port_arbiter;
   localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   mem_port_arbiter_if bus ();
   mem_port_arbiter #(.N(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   bit started = 1'b0;
   bit m_busy = 1'b0;
   int m_sel = 0;
   int m_ptr = 0;
   int m_cnt = 0;
   int glog[$];

   function automatic bit timed_out();
      return TO_EN && m_busy && !bus.mem_ready && m_cnt == TO - 1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_sel = 0;
         m_ptr = 0;
         m_cnt = 0;
         started = 1'b1;
      end else if (!m_busy) begin
         if (bus.req != 4'b0) begin
            for (int k = 0; k < 4; k++)
               if (bus.req[(m_ptr + k) % 4]) begin
                  m_sel = (m_ptr + k) % 4;
                  break;
               end
            m_busy = 1'b1;
            m_cnt = 0;
            glog.push_back(m_sel);
         end
      end else if (bus.mem_ready || timed_out()) begin
         m_busy = 1'b0;
         m_ptr = (m_sel + 1) % 4;
      end else m_cnt++;
   end

   logic [3:0] exp_grant, exp_done;
   always @(negedge clk)
      if (started) begin
         exp_grant = m_busy ? 4'(1 << m_sel) : 4'b0;
         exp_done = (m_busy && (bus.mem_ready || timed_out())) ? exp_grant : 4'b0;
         check("outputs", {bus.grant, bus.sel, bus.busy, bus.mem_valid, bus.done, bus.err},
               {exp_grant, 2'(m_sel), m_busy, m_busy, exp_done, timed_out()});
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   logic [3:0] d, rel;
   initial begin
      rst = 1'b1;
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      neg();
      check("reset_state", {bus.grant, bus.sel, bus.busy, bus.mem_valid, bus.done, bus.err}, 0);
      bus.req = 4'b0100;
      tick();
      neg();
      check("t1_grant", bus.grant, 4'b0100);
      check("t1_sel", bus.sel, 2);
      tick();
      tick();
      bus.mem_ready = 1'b1;
      neg();
      check("t1_done", bus.done, 4'b0100);
      tick();
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      neg();
      check("t1_idle", {bus.busy, bus.done}, 0);
      bus.req = 4'b0011;
      tick();
      bus.mem_ready = 1'b1;
      neg();
      check("wrap_first_sel", bus.sel, 0);
      check("wrap_first_done", bus.done, 4'b0001);
      tick();
      bus.req = 4'b0010;
      bus.mem_ready = 1'b0;
      tick();
      bus.mem_ready = 1'b1;
      neg();
      check("wrap_second_grant", bus.grant, 4'b0010);
      check("wrap_second_done", bus.done, 4'b0010);
      tick();
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      glog.delete();
      bus.req = 4'b1111;
      bus.mem_ready = 1'b1;
      rel = 4'b0;
      for (int c = 0; c < 16; c++) begin
         neg();
         d = bus.done;
         tick();
         for (int i = 0; i < 4; i++)
            if (d[i]) begin
               bus.req[i] = 1'b0;
               rel[i] = 1'b1;
            end else if (rel[i]) begin
               bus.req[i] = 1'b1;
               rel[i] = 1'b0;
            end
      end
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      check("rr_count", glog.size(), 8);
      for (int k = 0; k < glog.size(); k++) check("rr_order", glog[k], k % 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b1010;
      tick();
      bus.mem_ready = 1'b1;
      neg();
      check("late_first_done", bus.done, 4'b0010);
      tick();
      bus.req = 4'b1000;
      neg();
      check("stray_ready", {bus.busy, bus.done}, 0);
      tick();
      bus.mem_ready = 1'b0;
      neg();
      check("late_grant", bus.grant, 4'b1000);
      tick();
      bus.mem_ready = 1'b1;
      neg();
      check("late_done", bus.done, 4'b1000);
      tick();
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      bus.req = 4'b0010;
      tick();
      rst = 1'b1;
      neg();
      check("rst_mid_busy", {bus.busy, bus.done}, 5'b10000);
      tick();
      rst = 1'b0;
      neg();
      check("rst_values", {bus.grant, bus.sel, bus.busy, bus.done, bus.err}, 0);
      tick();
      neg();
      check("regrant", bus.grant, 4'b0010);
      bus.mem_ready = 1'b1;
      tick();
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      bus.req = 4'b0001;
      tick();
      tick();
      tick();
      tick();
      neg();
`ifdef ARB_TIMEOUT_EN
      check("timeout_err", bus.err, 1);
      check("timeout_done", bus.done, 4'b0001);
      tick();
      bus.req = 4'b0;
      neg();
      check("timeout_idle", bus.busy, 0);
`else
      check("no_timeout_err", bus.err, 0);
      check("no_timeout_busy", {bus.busy, bus.done}, 5'b10000);
      tick();
      neg();
      check("no_timeout_still_busy", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 4'b0;
`endif
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer for the single shared memory port used by the core: instruction fetch, load/store unit, debug/loader and DMA. It grants one of four requesters at a time. It drives the 2-bit `sel` of the N-bit 4:1 muxes that steer address/write-data/write-enable into the memory, and it holds that selection stable until the memory completes. It owns the request/grant/done handshake with requesters and the valid/ready handshake with the memory.

## Interface
Parameters:
- `N`, 32: data width of muxed memory path (documentation only; arbiter carries no data)
- `TIMEOUT`, 16: max BUSY cycles before abort; used only with `ARB_TIMEOUT_EN`; legal 2..255

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  4  level request per requester; bit i = requester i
- `grant`  out  4  one-hot registered grant; all-zero when idle
- `sel`  out  2  binary index of granted requester, to 4:1 mux `sel`
- `busy`  out  1  transaction in progress (state BUSY)
- `mem_valid`  out  1  request valid to memory; equals `busy`
- `mem_ready`  in  1  memory completes current access this cycle
- `done`  out  4  one-cycle completion pulse to granted requester
- `err`  out  1  one-cycle abort pulse (timeout); constant 0 without macro

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if `req` != 0, pick a winner by round-robin. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4), and the first set bit wins. Register `grant`=onehot(win) and `sel`=win, then go to BUSY. If `req` == 0, stay in IDLE with `grant`=0 and `sel` holding its last value so the mux output does not toggle.
- BUSY: `mem_valid`=1 and `grant`/`sel` are frozen. When `mem_ready`=1:
  - `done`=`grant` combinationally in that cycle.
  - Next state is IDLE.
  - `ptr` <= `sel`+1 (wraps 3→0).
- Requester protocol: a requester keeps `req` high from assertion until it samples `done`, then deasserts it at that edge. A `req` still high in the following IDLE cycle counts as a new request.
- `req` dropped during BUSY is a protocol violation. The arbiter ignores it and keeps the grant until `mem_ready`.
- `mem_ready` while IDLE is ignored, and `done` stays 0.
- Requests arriving during BUSY wait; they are arbitrated at the next IDLE cycle.
- Fairness: a continuously requesting set is served in rotation. Each requester waits at most 3 transactions.
- Reset values: state IDLE, `grant`=0, `sel`=0, `ptr`=0, `busy`=0, `mem_valid`=0, `done`=0, `err`=0, timeout counter 0.
- Reset asserted mid-BUSY aborts the transaction with no `done` or `err` pulse. The next cycle is IDLE with reset values.

## Timing
- Grant latency: `req` seen high in IDLE at edge k gives `grant`/`sel`/`mem_valid` high after edge k.
- Completion: `done` is in the same cycle as `mem_ready`. The FSM is in IDLE after the next edge.
- Minimum transaction is 2 cycles (1 BUSY + 1 IDLE). Peak throughput is one access per 2 cycles.
- `sel` is stable for the whole BUSY interval, so mux outputs settle by the cycle after grant.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without `mem_ready`.
  - When the count reaches `TIMEOUT`-1 with `mem_ready`=0, `err` and `done`=`grant` pulse for that cycle. The FSM goes to IDLE and `ptr` advances as for a normal completion.
  - `mem_ready` in that same cycle takes precedence: normal completion, `err`=0.
- `ARB_TIMEOUT_EN` undefined: no counter, `err` tied to 0, `TIMEOUT` ignored, and BUSY waits indefinitely.

## Structure
- Shared package `arb_pkg`:
  - state encoding (IDLE=0, BUSY=1)
  - `NREQ`=4
  - `SEL_W`=2
  - timeout counter width 8
- Sub-module `rr_pick`: purely combinational. Inputs are `req[3:0]` and `ptr[1:0]`; outputs are `win[1:0]` and `any`. Instantiated once, with no state.
- The top level holds the FSM, `ptr`, grant/sel registers and the optional timeout counter. The 4:1 data muxes are instantiated by the parent, not inside this block.

## Test plan
- Reset then single request: `req`=0100, `mem_ready` high on 3rd BUSY cycle → `grant`=0100 and `sel`=2 one cycle after `req`; `done`=0100 for one cycle with `mem_ready`; IDLE next; `ptr`=3.
- All requesting: `req`=1111 held, with each requester releasing after its `done` and re-requesting 1 cycle later; `mem_ready` on first BUSY cycle → grant order 0,1,2,3,0,… with one IDLE cycle between grants.
- Wrap-around: `ptr`=3 (after serving requester 2), `req`=0011 → requester 0 wins, then 1.
- Late arrival and stray ready: during requester 1's BUSY, raise `req[3]`; also pulse `mem_ready` while IDLE → `done` stays 0 during the IDLE pulse; requester 3 is granted in the IDLE cycle after requester 1's `done`.
- Reset mid-BUSY: `rst` for 1 cycle while BUSY with `req`=0010 → no `done`; outputs at reset values; `ptr`=0; requester 1 is regranted afterwards.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT`=4): grant requester 0, hold `mem_ready`=0 → on 4th BUSY cycle `err`=1 and `done`=0001; IDLE next. Without the macro, the same stimulus keeps BUSY and `err` stays 0.
